tpu_dma_mem_responder: RTL and testbench
========================================

Name: tpu_dma_mem_responder

Overview:
Memory-side responder for the TPU DMA master port (dma_req/dma_wr/dma_addr/dma_wdata/dma_rdata/dma_ack). It services single-word reads and writes to a word-organised SRAM after a programmable latency. A host preload/readback port fills weights and activations and reads outputs. The block sits between tpu_top and the SoC memory fabric, and serves as the standalone memory model for TPU end-to-end benches.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored (power of two).
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to 4*DEPTH_WORDS).
LATENCY, 2, cycles from request capture to dma_ack (legal range 1..15).
ERR_DATA, 32'hDEAD_BEEF, read data returned for an illegal access.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
dma_req  in  1  request valid from TPU; held until ack.
dma_wr  in  1  1 = write, 0 = read; stable while dma_req is high.
dma_addr  in  32  byte address; stable while dma_req is high.
dma_wdata  in  32  write data; stable while dma_req is high.
dma_rdata  out  32  read data; valid in the ack cycle, held until the next ack.
dma_ack  out  1  single-cycle completion pulse.
host_we  in  1  host write strobe.
host_idx  in  $clog2(DEPTH_WORDS)  host word index.
host_wdata  in  32  host write data.
host_rdata  out  32  host read data; registered, 1-cycle latency.
err_sticky  out  1  set on any illegal DMA access.
err_clr  in  1  clears err_sticky.
rd_count  out  16  completed DMA reads; saturates at 16'hFFFF.
wr_count  out  16  completed DMA writes; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - dma_ack=0, dma_rdata=0, host_rdata=0, err_sticky=0, rd_count=0, wr_count=0.
  - SRAM contents are not cleared. Reset mid-transaction abandons that transaction with no write commit.
- FSM IDLE:
  - On a rising edge with dma_req=1, capture wr/addr/wdata, load lat_cnt=LATENCY-1, go to WAIT.
  - If LATENCY=1, go straight to RESP.
- FSM WAIT: lat_cnt decrements each cycle. When lat_cnt reaches 1, go to RESP.
- FSM RESP (one cycle):
  - dma_ack=1.
  - A write commits to SRAM at this edge.
  - A read drives dma_rdata from SRAM at this edge, so it is visible in the ack cycle.
  - Increment the matching counter.
  - Return to IDLE.
- Latency: request captured at edge t gives dma_ack high during cycle t+LATENCY.
- dma_req is ignored in RESP. The requester must drop dma_req, or present a new transaction, in the cycle after ack. dma_req still high in IDLE after ack is treated as a new request.
- A dma_req deassert before ack is a protocol violation; the captured transaction still completes.
- Address decode: idx = (addr - BASE_ADDR) >> 2. The access is illegal if addr[1:0]!=0 or addr is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS). An illegal access:
  - still acks with normal latency;
  - reads return ERR_DATA; writes are dropped;
  - sets err_sticky;
  - does not increment counters.
- err_sticky: if set and err_clr occur in the same cycle, set wins.
- Host port: independent second port.
  - host_rdata returns the word at host_idx one cycle later.
  - A host write and a DMA commit to the same word in the same cycle: the DMA data wins.
  - A host read of a word written the same cycle returns the old data.
- Counters hold at 16'hFFFF.

Decomposition:
- tpu_pkg gets:
  - responder FSM state enum (IDLE, WAIT, RESP);
  - DMA_ERR_DATA default;
  - a dma_req_t struct (wr, addr, wdata).
- One sub-module, tpu_dp_sram (DEPTH, WIDTH; two synchronous ports, port-A write priority), so it can be swapped for a macro.

Test Plan:
- Host writes word 5 = 32'h0000_0010 → DMA read at addr 0x14 with LATENCY=2: dma_ack rises exactly 2 cycles after the req edge, dma_rdata=32'h10, rd_count=1.
- DMA write 32'hCAFE_0001 to 0x20, then host read of idx 8 → host_rdata=32'hCAFE_0001 one cycle later; wr_count=1.
- DMA read at 0x1002 (misaligned), then at BASE_ADDR+4*DEPTH_WORDS → both ack, dma_rdata=32'hDEAD_BEEF, err_sticky=1, counters unchanged; err_clr pulse → err_sticky=0.
- Back-to-back reads with dma_req held high across ack, at 0x0 then 0x4 → two acks separated by exactly LATENCY+1 cycles, correct data each.
- Same-cycle host write 32'h1 and DMA commit 32'h2 to word 3 → SRAM word 3=32'h2.
- rst_n asserted in the WAIT state of a write → no ack, target word unchanged, all outputs 0; after release, a new request is serviced normally.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types for the TPU DMA memory responder: FSM states, request record, error fill word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Returned on reads that miss the window or are misaligned; easy to spot in dumps.
  localparam logic [31:0] DMA_ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dma_req_t;

endpackage

// File: rtl/tpu_dp_sram.sv
// Two-port synchronous SRAM model; port A write wins over port B on a same-word collision.
// Latency: 1 cycle read, read-before-write (a same-cycle write is not seen by the read).
// Backpressure: none; both ports accept every cycle.
module tpu_dp_sram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_we,
  input  logic             a_re,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_we,
  input  logic             b_re,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic [WIDTH-1:0] b_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array writes; port B is suppressed when port A hits the same word.
  always_ff @(posedge clk) begin
    if (b_we && !(a_we && (a_addr == b_addr))) mem[b_addr] <= b_wdata;
    if (a_we) mem[a_addr] <= a_wdata;
  end

  // Read registers hold their last value until the port reads again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_re) a_rdata <= mem[a_addr];
      if (b_re) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/tpu_dma_mem_responder.sv
// Memory-side responder for the TPU DMA port plus an independent host preload/readback port.
// Latency: dma_ack LATENCY cycles after the capture edge; host_rdata 1 cycle after host_idx.
// Backpressure: one transaction in flight; dma_req is held by the requester until dma_ack.
module tpu_dma_mem_responder
  import tpu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] ERR_DATA    = DMA_ERR_DATA,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [31:0]   dma_addr,
  input  logic [31:0]   dma_wdata,
  output logic [31:0]   dma_rdata,
  output logic          dma_ack,
  input  logic          host_we,
  input  logic [AW-1:0] host_idx,
  input  logic [31:0]   host_wdata,
  output logic [31:0]   host_rdata,
  output logic          err_sticky,
  input  logic          err_clr,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
);

  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

  resp_state_t   state_q, state_d;
  logic [3:0]    lat_cnt_q, lat_cnt_d;
  dma_req_t      req_q, cur_req;
  logic          launch;
  logic [31:0]   offset;
  logic          legal;
  logic [AW-1:0] word_idx;
  logic          rd_err_q;
  logic [31:0]   sram_a_q;

  // The transaction being launched: live bus in IDLE (only launches there when LATENCY==1), else the captured copy.
  always_comb begin
    cur_req = req_q;
    if (state_q == IDLE) cur_req = {dma_wr, dma_addr, dma_wdata};
  end

  // Window decode; addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  always_comb begin
    offset   = cur_req.addr - BASE_ADDR;
    legal    = (offset[1:0] == 2'b00) && ({1'b0, offset} < SPAN);
    word_idx = offset[AW+1:2];
  end

  // Next state; the SRAM access is launched on the edge that enters RESP so read data is visible with the ack.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    launch    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dma_req) begin
          if (LATENCY == 1) begin
            state_d = RESP;
            launch  = 1'b1;
          end else begin
            state_d   = WAIT;
            lat_cnt_d = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          state_d = RESP;
          launch  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latency counter and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      req_q     <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      if (state_q == IDLE && dma_req) req_q <= {dma_wr, dma_addr, dma_wdata};
    end
  end

  // Error flag, read-data select and saturating completion counters, all updated at launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_err_q   <= 1'b0;
      err_sticky <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
    end else begin
      if (launch && !cur_req.wr) rd_err_q <= !legal;
      if (launch && !legal) err_sticky <= 1'b1;
      else if (err_clr)     err_sticky <= 1'b0;
      if (launch && legal && !cur_req.wr && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      if (launch && legal &&  cur_req.wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
  end

  assign dma_ack   = (state_q == RESP);
  assign dma_rdata = rd_err_q ? ERR_DATA : sram_a_q;

  tpu_dp_sram #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (32)
  ) u_sram (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_we    (launch && legal && cur_req.wr),
    .a_re    (launch && legal && !cur_req.wr),
    .a_addr  (word_idx),
    .a_wdata (cur_req.wdata),
    .a_rdata (sram_a_q),
    .b_we    (host_we),
    .b_re    (1'b1),
    .b_addr  (host_idx),
    .b_wdata (host_wdata),
    .b_rdata (host_rdata)
  );

endmodule

// File: tb/tb_tpu_dma_mem_responder.sv
// Directed bench for tpu_dma_mem_responder at default parameters (LATENCY=2, BASE=0, 1024 words).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: every wait for dma_ack is bounded by a cycle budget.
module tb_tpu_dma_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dma_req, dma_wr;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic        host_we;
  logic [9:0]  host_idx;
  logic [31:0] host_wdata, host_rdata;
  logic        err_sticky, err_clr;
  logic [15:0] rd_count, wr_count;

  int n_checks = 0;
  int n_err    = 0;
  int lat;

  always #5 clk = ~clk;

  tpu_dma_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dma_req    (dma_req),
    .dma_wr     (dma_wr),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_rdata  (dma_rdata),
    .dma_ack    (dma_ack),
    .host_we    (host_we),
    .host_idx   (host_idx),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .err_sticky (err_sticky),
    .err_clr    (err_clr),
    .rd_count   (rd_count),
    .wr_count   (wr_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [9:0] idx, input logic [31:0] data);
    host_we = 1'b1; host_idx = idx; host_wdata = data;
    step();
    host_we = 1'b0;
  endtask

  // Raise a request and step until dma_ack; returns edges counted including the capture edge.
  task automatic dma_go(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, output int n);
    dma_req = 1'b1; dma_wr = wr; dma_addr = addr; dma_wdata = wdata;
    n = 0;
    do begin
      step();
      n++;
    end while (!dma_ack && n < 20);
    dma_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_wdata = '0;
    host_we = 1'b0; host_idx = '0; host_wdata = '0; err_clr = 1'b0;
    step(); step();
    chk("rst_ack", dma_ack, 0);
    chk("rst_rdata", dma_rdata, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    rst_n = 1'b1;
    step();

    // Preload
    host_wr(10'd5, 32'h0000_0010);
    host_wr(10'd0, 32'h0000_00A0);
    host_wr(10'd1, 32'h0000_00A1);
    host_wr(10'd9, 32'h0000_0090);
    host_wr(10'd12, 32'h0000_0C0C);

    // Host write and read of the same word in one cycle returns the old word
    host_we = 1'b1; host_idx = 10'd9; host_wdata = 32'h0000_0099;
    step();
    host_we = 1'b0;
    chk("host_rbw_old", host_rdata, 32'h0000_0090);
    step();
    chk("host_rbw_new", host_rdata, 32'h0000_0099);

    // Simple read
    dma_go(1'b0, 32'h14, 32'h0, lat);
    chk("rd_latency", lat, 2);
    chk("rd_data", dma_rdata, 32'h0000_0010);
    chk("rd_count1", rd_count, 1);
    step();
    chk("rd_ack_pulse", dma_ack, 0);
    chk("rd_data_held", dma_rdata, 32'h0000_0010);

    // Write then host readback
    dma_go(1'b1, 32'h20, 32'hCAFE_0001, lat);
    chk("wr_latency", lat, 2);
    chk("wr_count1", wr_count, 1);
    host_idx = 10'd8;
    step();
    chk("wr_ack_pulse", dma_ack, 0);
    chk("wr_host_rb", host_rdata, 32'hCAFE_0001);

    // Illegal accesses
    dma_go(1'b0, 32'h1002, 32'h0, lat);
    chk("mis_latency", lat, 2);
    chk("mis_rdata", dma_rdata, 32'hDEAD_BEEF);
    chk("mis_err", err_sticky, 1);
    step();
    dma_go(1'b0, 32'h1000, 32'h0, lat);
    chk("oor_latency", lat, 2);
    chk("oor_rdata", dma_rdata, 32'hDEAD_BEEF);
    chk("oor_rd_count", rd_count, 1);
    chk("oor_wr_count", wr_count, 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cleared", err_sticky, 0);

    // Set beats clear when both land on the same edge
    err_clr = 1'b1;
    dma_go(1'b0, 32'hFFFF_FFFC, 32'h0, lat);
    chk("wrap_rdata", dma_rdata, 32'hDEAD_BEEF);
    chk("err_set_wins", err_sticky, 1);
    step();
    chk("err_clr_after", err_sticky, 0);
    err_clr = 1'b0;

    // Illegal write must not land anywhere
    dma_go(1'b1, 32'h0000_0023, 32'h5555_5555, lat);
    chk("illegal_wr_count", wr_count, 1);
    host_idx = 10'd8;
    step();
    chk("illegal_wr_dropped", host_rdata, 32'hCAFE_0001);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // Back-to-back reads with dma_req held across the ack
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h0;
    lat = 0;
    do begin step(); lat++; end while (!dma_ack && lat < 20);
    chk("b2b_lat0", lat, 2);
    chk("b2b_data0", dma_rdata, 32'h0000_00A0);
    dma_addr = 32'h4;
    lat = 0;
    do begin step(); lat++; end while (!dma_ack && lat < 20);
    chk("b2b_gap", lat, 3);
    chk("b2b_data1", dma_rdata, 32'h0000_00A1);
    chk("b2b_rd_count", rd_count, 3);
    dma_req = 1'b0;
    step();
    chk("b2b_ack_low", dma_ack, 0);

    // Host write and DMA commit hit word 3 on the same edge
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'hC; dma_wdata = 32'h2;
    step();
    host_we = 1'b1; host_idx = 10'd3; host_wdata = 32'h1;
    step();
    host_we = 1'b0;
    chk("coll_ack", dma_ack, 1);
    chk("coll_wr_count", wr_count, 2);
    dma_req = 1'b0;
    step();
    chk("coll_word3", host_rdata, 32'h2);

    // Reset while a write waits: no commit, outputs cleared
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h30; dma_wdata = 32'h0000_0BAD;
    step();
    chk("rstw_no_ack_yet", dma_ack, 0);
    rst_n = 1'b0;
    #2;
    chk("rstw_ack", dma_ack, 0);
    chk("rstw_rdata", dma_rdata, 0);
    chk("rstw_host_rdata", host_rdata, 0);
    chk("rstw_err", err_sticky, 0);
    chk("rstw_rd_count", rd_count, 0);
    chk("rstw_wr_count", wr_count, 0);
    dma_req = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rstw_idle_ack", dma_ack, 0);
    host_idx = 10'd12;
    step();
    chk("rstw_word_kept", host_rdata, 32'h0000_0C0C);
    chk("rstw_wr_count_after", wr_count, 0);

    dma_go(1'b0, 32'h14, 32'h0, lat);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_data", dma_rdata, 32'h0000_0010);
    chk("post_rst_rd_count", rd_count, 1);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
